lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
//
// Purpose:
//   Load/store unit controller sitting between a core and a simple
//   req/gnt/rvalid memory bus. It accepts one access at a time, generates
//   word-aligned bus beats with byte enables, places store data on the
//   correct byte lanes and realigns plus sign/zero-extends load data.
//
// Configuration macro:
//   LSU_MISALIGNED_SPLIT_EN
//     defined   : accesses crossing a word boundary are split into two bus
//                 beats (address, address+4) and lsu_err_o stays 0.
//     undefined : accesses crossing a word boundary are rejected without any
//                 bus traffic and complete with lsu_err_o=1, lsu_rdata_o=0.
//
// Ports:
//   clk, rst        : clock (rising edge) and synchronous active-high reset
//   lsu_req_i       : core request valid, taken when lsu_ready_o is high
//   lsu_we_i        : 0 = load, 1 = store
//   lsu_type_i      : 00 word, 01 half, 10/11 byte
//   lsu_sext_i      : sign-extend (1) or zero-extend (0) load data
//   lsu_addr_i      : byte address
//   lsu_wdata_i     : store data, right-aligned
//   lsu_ready_o     : controller idle and able to accept
//   lsu_rvalid_o    : one-cycle completion pulse
//   lsu_rdata_o     : extended load data (0 for stores)
//   lsu_err_o       : misaligned-access error, coincident with lsu_rvalid_o
//   data_*          : memory bus (req/gnt handshake, then rvalid response)
// ---------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [1:0]            lsu_type_i,
    input  logic                  lsu_sext_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_ready_o,
    output logic                  lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    output logic                  lsu_err_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i
);

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        GNT1,
        RSP1,
        GNT2,
        RSP2
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_we;
    logic [1:0]              r_type;
    logic                    r_sext;
    logic [1:0]              r_off;
    logic [7:0]              r_mask;
    logic [2*DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0]   r_beat1;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;

    logic                    w_accept;
    logic [1:0]              w_off;
    logic [7:0]              w_baseMask;
    logic [7:0]              w_mask;
    logic                    w_misaligned;
    logic                    w_reject;
    logic                    w_rMis;
    logic [2*DATA_WIDTH-1:0] w_shiftWdata;
    logic                    w_busReq;
    logic                    w_secondBeat;
    logic [DATA_WIDTH-1:0]   w_beatLo;
    logic [DATA_WIDTH-1:0]   w_beatHi;
    logic [DATA_WIDTH-1:0]   w_rdAligned;
    logic [DATA_WIDTH-1:0]   w_loadData;
    logic                    w_final;

    // Request decode: the byte mask is built over two words so that an
    // access spilling into the next word shows up in the upper nibble.
    assign w_accept     = lsu_req_i & (r_state == IDLE);
    assign w_off        = lsu_addr_i[1:0];
    assign w_mask       = w_baseMask << w_off;
    assign w_misaligned = |w_mask[7:4];
    assign w_reject     = w_misaligned & ~SPLIT_EN;
    assign w_rMis       = |r_mask[7:4];
    assign w_shiftWdata = {{DATA_WIDTH{1'b0}}, lsu_wdata_i} << {w_off, 3'b000};

    always_comb begin
        w_baseMask = 8'b0000_0001;
        case (lsu_type_i)
            2'b00:   w_baseMask = 8'b0000_1111;
            2'b01:   w_baseMask = 8'b0000_0011;
            default: w_baseMask = 8'b0000_0001;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A rejected misaligned access never leaves IDLE;
    // RSP1 only continues to a second beat when the access spans two words.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_reject) begin
                    w_nextState = GNT1;
                end
            end
            GNT1: begin
                if (data_gnt_i) begin
                    w_nextState = RSP1;
                end
            end
            RSP1: begin
                if (data_rvalid_i) begin
                    w_nextState = w_rMis ? GNT2 : IDLE;
                end
            end
            GNT2: begin
                if (data_gnt_i) begin
                    w_nextState = RSP2;
                end
            end
            RSP2: begin
                if (data_rvalid_i) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Bus drive: everything is forced to zero outside the grant states so
    // the bus is quiet after reset and between transactions.
    assign w_busReq     = (r_state == GNT1) || (r_state == GNT2);
    assign w_secondBeat = (r_state == GNT2);

    assign data_req_o   = w_busReq;
    assign data_we_o    = w_busReq & r_we;
    assign data_addr_o  = !w_busReq    ? '0 :
                          w_secondBeat ? r_addr + ADDR_WIDTH'(4) : r_addr;
    assign data_be_o    = !w_busReq    ? 4'b0000 :
                          w_secondBeat ? r_mask[7:4] : r_mask[3:0];
    assign data_wdata_o = !w_busReq    ? '0 :
                          w_secondBeat ? r_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                       : r_wdata[DATA_WIDTH-1:0];

    // Load realignment: in RSP2 the pair is {current beat, captured beat 1};
    // a single-beat access only needs the current word shifted down.
    assign w_beatLo    = (r_state == RSP2) ? r_beat1 : data_rdata_i;
    assign w_beatHi    = (r_state == RSP2) ? data_rdata_i : '0;
    assign w_rdAligned = DATA_WIDTH'({w_beatHi, w_beatLo} >> {r_off, 3'b000});
    assign w_final     = data_rvalid_i &&
                         (((r_state == RSP1) && !w_rMis) || (r_state == RSP2));

    always_comb begin
        w_loadData = w_rdAligned;
        case (r_type)
            2'b00:   w_loadData = w_rdAligned;
            2'b01:   w_loadData = {{(DATA_WIDTH-16){r_sext & w_rdAligned[15]}},
                                   w_rdAligned[15:0]};
            default: w_loadData = {{(DATA_WIDTH-8){r_sext & w_rdAligned[7]}},
                                   w_rdAligned[7:0]};
        endcase
    end

    // Request capture and registered completion. The completion outputs
    // default to zero each cycle so lsu_rvalid_o/lsu_err_o are single pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_type   <= 2'b00;
            r_sext   <= 1'b0;
            r_off    <= 2'b00;
            r_mask   <= 8'b0;
            r_wdata  <= '0;
            r_beat1  <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            if (w_accept) begin
                r_addr  <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                r_we    <= lsu_we_i;
                r_type  <= lsu_type_i;
                r_sext  <= lsu_sext_i;
                r_off   <= w_off;
                r_mask  <= w_mask;
                r_wdata <= w_shiftWdata;
                if (w_reject) begin
                    r_rvalid <= 1'b1;
                    r_err    <= 1'b1;
                end
            end
            if ((r_state == RSP1) && data_rvalid_i && w_rMis) begin
                r_beat1 <= data_rdata_i;
            end
            if (w_final) begin
                r_rvalid <= 1'b1;
                r_rdata  <= r_we ? '0 : w_loadData;
            end
        end
    end

    assign lsu_ready_o  = (r_state == IDLE);
    assign lsu_rvalid_o = r_rvalid;
    assign lsu_rdata_o  = r_rdata;
    assign lsu_err_o    = r_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
//
// Purpose:
//   Self-checking bench for lsu_ctrl. A byte-addressed reference memory
//   predicts every completion; expectations are queued at accept time and a
//   monitor pops them whenever the DUT pulses lsu_rvalid_o. A separate bus
//   slave with its own word memory answers the DUT with configurable grant
//   and response delays, so wrong byte lanes show up on later loads.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_type_i;
    logic        lsu_sext_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_ready_o;
    logic        lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .lsu_req_i    (lsu_req_i),
        .lsu_we_i     (lsu_we_i),
        .lsu_type_i   (lsu_type_i),
        .lsu_sext_i   (lsu_sext_i),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_ready_o  (lsu_ready_o),
        .lsu_rvalid_o (lsu_rvalid_o),
        .lsu_rdata_o  (lsu_rdata_o),
        .lsu_err_o    (lsu_err_o),
        .data_req_o   (data_req_o),
        .data_gnt_i   (data_gnt_i),
        .data_addr_o  (data_addr_o),
        .data_we_o    (data_we_o),
        .data_be_o    (data_be_o),
        .data_wdata_o (data_wdata_o),
        .data_rvalid_i(data_rvalid_i),
        .data_rdata_i (data_rdata_i)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acceptCycle;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          reqCycles;
    } beat_t;

    exp_t        expQ[$];
    beat_t       busLog[$];
    exp_t        monE;
    beat_t       slaveBeat;
    logic [7:0]  refMem [1024];
    logic [31:0] busMem [256];
    int          tests = 0;
    int          fails = 0;
    int          cycle = 0;
    int          gntDelay = 0;
    int          rspDelay = 0;
    bit          noise = 1'b0;
    bit          logEnable = 1'b0;
    int          waitCnt = 0;
    bit          pending = 1'b0;
    int          rspCnt = 0;
    logic [31:0] pendData;
    logic [68:0] holdVec;
    logic [7:0]  slaveIdx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Central comparison: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [71:0] actual,
                               input logic [71:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    // Reference model: plain byte-array memory, little-endian.
    function automatic int sizeOf(input logic [1:0] t);
        return (t == 2'b00) ? 4 : (t == 2'b01) ? 2 : 1;
    endfunction

    function automatic bit modelMisaligned(input int addr, input logic [1:0] t);
        return ((addr % 4) + sizeOf(t)) > 4;
    endfunction

    function automatic logic [31:0] modelLoad(input int addr, input logic [1:0] t,
                                              input logic sext);
        int          n;
        logic [31:0] v;
        n = sizeOf(t);
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[(addr + i) % 1024];
        if (sext && n < 4 && v[8*n-1]) begin
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic setWord(input int addr, input logic [31:0] w);
        busMem[(addr / 4) % 256] = w;
        for (int b = 0; b < 4; b++) refMem[((addr / 4) * 4 + b) % 1024] = w[8*b +: 8];
    endtask

    // Bus slave: grants after gntDelay extra cycles, answers after rspDelay
    // extra cycles, and optionally injects gnt/rvalid noise where the DUT
    // must ignore it. Inputs change on the falling edge only.
    always @(negedge clk) begin
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = $urandom;
        if (rst) waitCnt = 0;
        if (pending) begin
            if (rspCnt == 0) begin
                data_rvalid_i = 1'b1;
                data_rdata_i  = pendData;
                pending       = 1'b0;
            end else begin
                rspCnt--;
                if (noise) data_gnt_i = ($urandom_range(0, 3) == 0);
            end
        end else if (data_req_o && !rst) begin
            if (waitCnt == 0) begin
                holdVec = {data_addr_o, data_be_o, data_we_o, data_wdata_o};
            end else begin
                checkOutput("busHold", 72'({data_addr_o, data_be_o, data_we_o, data_wdata_o}),
                            72'(holdVec));
            end
            if (waitCnt >= gntDelay) begin
                data_gnt_i = 1'b1;
                slaveIdx   = data_addr_o[9:2];
                if (data_we_o) begin
                    for (int b = 0; b < 4; b++) begin
                        if (data_be_o[b]) busMem[slaveIdx][8*b +: 8] = data_wdata_o[8*b +: 8];
                    end
                end
                pendData = busMem[slaveIdx];
                if (logEnable) begin
                    slaveBeat.addr      = data_addr_o;
                    slaveBeat.be        = data_be_o;
                    slaveBeat.we        = data_we_o;
                    slaveBeat.wdata     = data_wdata_o;
                    slaveBeat.reqCycles = waitCnt + 1;
                    busLog.push_back(slaveBeat);
                end
                pending = 1'b1;
                rspCnt  = rspDelay;
                waitCnt = 0;
            end else begin
                waitCnt++;
                if (noise) data_rvalid_i = ($urandom_range(0, 3) == 0);
            end
        end else if (noise) begin
            data_gnt_i = ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: every completion pulse is matched against the oldest
    // expectation; a pulse with nothing outstanding is itself an error.
    always @(negedge clk) begin
        if (!rst && lsu_rvalid_o) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRvalid", 72'(1), 72'(0));
            end else begin
                monE = expQ.pop_front();
                checkOutput("rdata", 72'(lsu_rdata_o), 72'(monE.rdata));
                checkOutput("err", 72'(lsu_err_o), 72'(monE.err));
                if (monE.lat >= 0) begin
                    checkOutput("latency", 72'(cycle - monE.acceptCycle), 72'(monE.lat));
                end
            end
        end
    end

    // Issue one request, wait for it to be accepted and queue its expected
    // completion. Directed calls supply their own literal expectation.
    task automatic applyStimulus(input logic we, input logic [1:0] t, input logic sext,
                                 input int addr, input logic [31:0] wdata,
                                 input bit track, input bit direct,
                                 input logic [31:0] dRdata, input logic dErr,
                                 input int dLat);
        exp_t e;
        int   waited;
        bit   rejected;
        @(negedge clk);
        lsu_req_i   = 1'b1;
        lsu_we_i    = we;
        lsu_type_i  = t;
        lsu_sext_i  = sext;
        lsu_addr_i  = 32'(addr);
        lsu_wdata_i = wdata;
        waited = 0;
        while (!lsu_ready_o && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!lsu_ready_o) begin
            checkOutput("acceptTimeout", 72'(0), 72'(1));
            lsu_req_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        lsu_req_i     = 1'b0;
        rejected      = modelMisaligned(addr, t) && !SPLIT;
        e.acceptCycle = cycle - 1;
        if (direct) begin
            e.rdata = dRdata;
            e.err   = dErr;
            e.lat   = dLat;
        end else begin
            e.rdata = (we || rejected) ? 32'h0 : modelLoad(addr, t, sext);
            e.err   = rejected;
            e.lat   = rejected ? 1 : -1;
        end
        if (we && !rejected) begin
            for (int i = 0; i < sizeOf(t); i++) refMem[(addr + i) % 1024] = wdata[8*i +: 8];
        end
        if (track) expQ.push_back(e);
    endtask

    task automatic waitIdle();
        int w;
        w = 0;
        while (expQ.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (expQ.size() != 0) begin
            checkOutput("drainTimeout", 72'(expQ.size()), 72'(0));
            expQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic checkBeat(input string name, input int idx, input logic [31:0] addr,
                             input logic [3:0] be, input logic we, input logic [31:0] wdata,
                             input int reqCycles);
        beat_t b;
        if (busLog.size() <= idx) begin
            checkOutput({name, "Missing"}, 72'(busLog.size()), 72'(idx + 1));
            return;
        end
        b = busLog[idx];
        checkOutput({name, "Beat"},
                    72'({b.addr, b.be, b.we, (b.we ? b.wdata : 32'h0)}),
                    72'({addr, be, we, (we ? wdata : 32'h0)}));
        checkOutput({name, "ReqCycles"}, 72'(b.reqCycles), 72'(reqCycles));
    endtask

    initial begin
        int rvCount;
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          rvCount;
        logic [1:0]  t;
        rst         = 1'b1;
        lsu_req_i   = 1'b0;
        lsu_we_i    = 1'b0;
        lsu_type_i  = 2'b00;
        lsu_sext_i  = 1'b0;
        lsu_addr_i  = 32'h0;
        lsu_wdata_i = 32'h0;
        for (int i = 0; i < 256; i++) setWord(i * 4, $urandom);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstRvalid", 72'(lsu_rvalid_o), 72'(0));
        checkOutput("rstBusReq", 72'({data_req_o, data_be_o, data_we_o}), 72'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rstReady", 72'(lsu_ready_o), 72'(1));
        checkOutput("rstOutputs", 72'({lsu_rvalid_o, lsu_err_o, lsu_rdata_o}), 72'(0));

        // Aligned word load, minimum latency.
        logEnable = 1'b1;
        gntDelay  = 0;
        rspDelay  = 0;
        setWord(32'h100, 32'hDEADBEEF);
        busLog.delete();
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 3);
        waitIdle();
        checkBeat("lw", 0, 32'h100, 4'b1111, 1'b0, 32'h0, 1);

        // Byte loads in the top lane, signed and unsigned.
        setWord(32'h100, 32'h80000000);
        busLog.delete();
        applyStimulus(1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 1'b1, 1'b1, 32'hFFFFFF80, 1'b0, -1);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h103, 32'h0, 1'b1, 1'b1, 32'h00000080, 1'b0, -1);
        waitIdle();
        checkBeat("lb", 0, 32'h100, 4'b1000, 1'b0, 32'h0, 1);

        // Halfword store with a delayed grant, then read the word back.
        gntDelay = 3;
        busLog.delete();
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h102, 32'h00001234, 1'b1, 1'b1, 32'h0, 1'b0, -1);
        waitIdle();
        checkBeat("sh", 0, 32'h100, 4'b1100, 1'b1, 32'h12340000, 4);
        gntDelay = 0;
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 32'h12340000, 1'b0, -1);
        waitIdle();

`ifdef LSU_MISALIGNED_SPLIT_EN
        // Misaligned word load and store split over two words.
        setWord(32'h100, 32'h44332211);
        setWord(32'h104, 32'h88776655);
        busLog.delete();
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 1'b1, 1'b1, 32'h55443322, 1'b0, -1);
        waitIdle();
        checkBeat("lwMis0", 0, 32'h100, 4'b1110, 1'b0, 32'h0, 1);
        checkBeat("lwMis1", 1, 32'h104, 4'b0001, 1'b0, 32'h0, 1);
        busLog.delete();
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h103, 32'hAABBCCDD, 1'b1, 1'b1, 32'h0, 1'b0, -1);
        waitIdle();
        checkBeat("swMis0", 0, 32'h100, 4'b1000, 1'b1, 32'hDD000000, 1);
        checkBeat("swMis1", 1, 32'h104, 4'b0111, 1'b1, 32'h00AABBCC, 1);
`else
        // Misaligned word load is rejected without touching the bus.
        busLog.delete();
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 1);
        waitIdle();
        checkOutput("misNoBus", 72'(busLog.size()), 72'(0));
`endif

        // Reset while waiting for the response; the late rvalid is dropped.
        rspDelay = 6;
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, -1);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midRstReady", 72'(lsu_ready_o), 72'(1));
        checkOutput("midRstBus", 72'({data_req_o, lsu_rvalid_o, lsu_err_o}), 72'(0));
        rvCount = 0;
        repeat (12) begin
            @(negedge clk);
            if (lsu_rvalid_o) rvCount++;
        end
        checkOutput("lateRvalid", 72'(rvCount), 72'(0));
        rspDelay = 0;

        // Randomized traffic with bus noise against the reference model.
        logEnable = 1'b0;
        noise     = 1'b1;
        for (int n = 0; n < 400; n++) begin
            gntDelay = $urandom_range(0, 2);
            rspDelay = $urandom_range(0, 2);
            t        = 2'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 1023), $urandom, 1'b1, 1'b0,
                          32'h0, 1'b0, -1);
        end
        waitIdle();
        noise = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
